// File: rtl/peripheral_bridge_ahb2apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB4 bridge.
// The FSM state set, AHB encodings and the APB write-strobe helper live here.
package peripheral_ahb2apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B8  = 3'd0;
    localparam logic [2:0] HSIZE_B16 = 3'd1;
    localparam logic [2:0] HSIZE_B32 = 3'd2;
    localparam logic [2:0] HSIZE_B64 = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic logic [3:0] gen_pstrb(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] strb;
        case (hsize)
            HSIZE_B8:  strb = 4'b0001 << addr;
            HSIZE_B16: strb = 4'b0011 << {addr[1], 1'b0};
            default:   strb = 4'hF;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/peripheral_bridge_ahb2apb_if.sv
// AHB-Lite slave port plus APB4 master port of the bridge, bundled as one interface.
// slave = the bridge's view; master = the surrounding bus fabric / peripherals.
interface peripheral_bridge_ahb2apb_if #(
    parameter int PLEN       = 64,
    parameter int XLEN       = 64,
    parameter int PADDR_SIZE = 32,
    parameter int PDATA_SIZE = 32
);
    logic                  HSEL;
    logic [PLEN-1:0]       HADDR;
    logic [XLEN-1:0]       HWDATA;
    logic [XLEN-1:0]       HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    logic                  PSEL;
    logic                  PENABLE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic                  PWRITE;
    logic [PDATA_SIZE-1:0] PWDATA;
    logic [3:0]            PSTRB;
    logic [2:0]            PPROT;
    logic [PDATA_SIZE-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/peripheral_bridge_ahb2apb.sv
// AHB-Lite slave to APB4 master bridge, single clock (PCLK = HCLK).
// Every bus-facing output is a register loaded from the next-state decode.
module peripheral_bridge_ahb2apb
    import peripheral_ahb2apb_pkg::*;
#(
    parameter int PLEN       = 64,
    parameter int XLEN       = 64,
    parameter int PADDR_SIZE = 32,
    parameter int PDATA_SIZE = 32
) (
    input  logic HCLK,
    input  logic HRESETn,
    peripheral_bridge_ahb2apb_if.slave bus
);

    state_t                state_q, state_nxt;
    logic                  accept;
    logic                  lane_hi;
    logic [XLEN-1:0]       hwdata_sh;

    logic                  hreadyout_q;
    logic                  hresp_q;
    logic [XLEN-1:0]       hrdata_q;
    logic                  psel_q;
    logic                  penable_q;
    logic [PADDR_SIZE-1:0] paddr_q;
    logic                  pwrite_q;
    logic [PDATA_SIZE-1:0] pwdata_q;
    logic [3:0]            pstrb_q;
    logic [2:0]            pprot_q;

    // HREADYOUT is only high in IDLE/ERR2, so it doubles as the "may accept" qualifier.
    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout_q;

    assign lane_hi   = (XLEN == 64) ? paddr_q[2] : 1'b0;
    assign hwdata_sh = bus.HWDATA >> {lane_hi, 5'd0};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE, ERR2: begin
                state_nxt = IDLE;
                if (accept) begin
                    if (bus.HSIZE > HSIZE_B32) state_nxt = ERR1;
                    else if (bus.HWRITE)       state_nxt = WDATA;
                    else                       state_nxt = SETUP;
                end
            end
            WDATA:  state_nxt = SETUP;
            SETUP:  state_nxt = ACCESS;
            ACCESS: if (bus.PREADY) state_nxt = bus.PSLVERR ? ERR1 : IDLE;
            ERR1:   state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            hrdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= 4'h0;
            pprot_q     <= 3'b000;
        end else begin
            hreadyout_q <= state_nxt inside {IDLE, ERR2};
            hresp_q     <= (state_nxt inside {ERR1, ERR2}) ? HRESP_ERROR : HRESP_OKAY;
            psel_q      <= state_nxt inside {SETUP, ACCESS};
            penable_q   <= state_nxt == ACCESS;
            // Accept only happens with PSEL low, so the APB side never sees these move mid-transfer.
            if (accept) begin
                paddr_q  <= bus.HADDR[PADDR_SIZE-1:0];
                pwrite_q <= bus.HWRITE;
                pstrb_q  <= bus.HWRITE ? gen_pstrb(bus.HSIZE, bus.HADDR[1:0]) : 4'h0;
                pprot_q  <= {~bus.HPROT[0], 1'b0, bus.HPROT[1]};
            end
            if (state_q == WDATA) pwdata_q <= hwdata_sh[PDATA_SIZE-1:0];
            if (state_q == ACCESS && bus.PREADY && !bus.PSLVERR && !pwrite_q)
                hrdata_q <= {(XLEN/PDATA_SIZE){bus.PRDATA}};
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.PSTRB     = pstrb_q;
    assign bus.PPROT     = pprot_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.HBURST, bus.HMASTLOCK, bus.HPROT[3:2], bus.HTRANS[0],
                         bus.HADDR, hwdata_sh};

endmodule
